// File: rtl/hold_ctrl_pkg.sv
// Shared pipeline-control definitions: hold encodings, reset polarity, word
// constants and watchdog counter geometry. Imported by hold_ctrl and
// hold_watchdog.
package hold_ctrl_pkg;

    // Cumulative hold bus: each higher level also freezes every earlier stage.
    typedef logic [2:0] HoldFlagBus;

    localparam HoldFlagBus HoldNone = 3'b000;
    localparam HoldFlagBus HoldPc   = 3'b001;
    localparam HoldFlagBus HoldIf   = 3'b011;
    localparam HoldFlagBus HoldId   = 3'b111;

    localparam logic        RstEnable = 1'b1;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    // Watchdog hold-cycle counter.
    localparam int unsigned CntW = 9;
    localparam logic [CntW-1:0] CntMax = '1;

endpackage

// File: rtl/hold_watchdog.sv
// Stall watchdog: counts consecutive held cycles, saturates at the counter
// maximum, and raises a sticky flag once the count reaches TIMEOUT.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   hold_active    pipeline is held (hold_flag != HoldNone) this cycle
//   stall_timeout  sticky flag, cleared only by rst
module hold_watchdog
    import hold_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic hold_active,
    output logic stall_timeout
);

    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = '0;
        if (hold_active) begin
            cnt_nxt = (cnt == CntMax) ? cnt : cnt + 1'b1;
        end
    end

    // The flag is set on the same edge the counter reaches TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt           <= '0;
            stall_timeout <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (32'(cnt_nxt) >= TIMEOUT) begin
                stall_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hold_ctrl.sv
// Pipeline hold / redirect controller. Merges EX branch redirects, EX
// multi-cycle busy, instruction-bus wait and external interrupts into one
// cumulative hold bus and one PC redirect, with a stall watchdog.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   ex_jump_req, ex_jump_addr  EX taken branch/jump and its target
//   ex_pc                      PC of the instruction in EX (interrupt return)
//   ex_busy                    EX multi-cycle operation in progress
//   bus_hold                   instruction bus not granted
//   int_req, int_addr          interrupt request and handler vector
//   hold_flag                  cumulative hold (combinational)
//   jump_flag, jump_addr       PC redirect (combinational, addr 0 when idle)
//   int_ack                    interrupt taken this cycle (combinational)
//   int_epc                    registered return PC of last taken interrupt
//   stall_timeout              sticky watchdog flag
module hold_ctrl
    import hold_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_jump_req,
    input  logic [31:0] ex_jump_addr,
    input  logic [31:0] ex_pc,
    input  logic        ex_busy,
    input  logic        bus_hold,
    input  logic        int_req,
    input  logic [31:0] int_addr,
    output HoldFlagBus  hold_flag,
    output logic        jump_flag,
    output logic [31:0] jump_addr,
    output logic        int_ack,
    output logic [31:0] int_epc,
    output logic        stall_timeout
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        INT_TAKE = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   pending;
    logic   int_take;

    always_comb begin
        state_nxt = state;
        hold_flag = HoldNone;
        jump_flag = 1'b0;
        jump_addr = ZeroWord;
        int_ack   = 1'b0;
        int_take  = 1'b0;
        if (rst != RstEnable) begin
            // Interrupts only enter on a fully free RUN cycle so the EX
            // instruction at ex_pc is a clean return point.
            int_take = (state == RUN) && (pending || int_req) &&
                       !ex_jump_req && !ex_busy && !bus_hold;

            if (ex_jump_req || ex_busy || int_take) hold_flag = HoldId;
            else if (bus_hold)                      hold_flag = HoldPc;

            if (ex_jump_req) begin
                jump_flag = 1'b1;
                jump_addr = ex_jump_addr;
            end else if (int_take) begin
                jump_flag = 1'b1;
                jump_addr = int_addr;
            end
            int_ack = int_take;

            case (state)
                RUN: begin
                    if (ex_busy && !ex_jump_req) state_nxt = STALL;
                    else if (int_take)           state_nxt = INT_TAKE;
                end
                STALL:    if (!ex_busy) state_nxt = RUN;
                INT_TAKE: state_nxt = RUN;
                default:  state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state   <= RUN;
            pending <= 1'b0;
            int_epc <= ZeroWord;
        end else begin
            state <= state_nxt;
            // Requests seen during INT_TAKE are dropped, not queued.
            if (int_take)                        pending <= 1'b0;
            else if (int_req && state != INT_TAKE) pending <= 1'b1;
            if (int_take) int_epc <= ex_pc;
        end
    end

    hold_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk           (clk),
        .rst           (rst),
        .hold_active   (hold_flag != HoldNone),
        .stall_timeout (stall_timeout)
    );

endmodule

// File: tb/tb_hold_ctrl.sv
module tb_hold_ctrl;

    localparam int unsigned TO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_jump_req;
    logic [31:0] ex_jump_addr;
    logic [31:0] ex_pc;
    logic        ex_busy;
    logic        bus_hold;
    logic        int_req;
    logic [31:0] int_addr;
    logic [2:0]  hold_flag;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        int_ack;
    logic [31:0] int_epc;
    logic        stall_timeout;

    hold_ctrl #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_jump_req   (ex_jump_req),
        .ex_jump_addr  (ex_jump_addr),
        .ex_pc         (ex_pc),
        .ex_busy       (ex_busy),
        .bus_hold      (bus_hold),
        .int_req       (int_req),
        .int_addr      (int_addr),
        .hold_flag     (hold_flag),
        .jump_flag     (jump_flag),
        .jump_addr     (jump_addr),
        .int_ack       (int_ack),
        .int_epc       (int_epc),
        .stall_timeout (stall_timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    bit          m_pend  = 1'b0;  // interrupt remembered but not yet taken
    bit          m_stall = 1'b0;  // inside a busy stall entered from normal flow
    bit          m_took  = 1'b0;  // previous cycle took an interrupt
    bit          m_to    = 1'b0;
    int          m_cnt   = 0;
    logic [31:0] m_epc   = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_take();
        return !rst && !m_stall && !m_took && (m_pend || int_req) &&
               !ex_jump_req && !ex_busy && !bus_hold;
    endfunction

    function automatic logic [2:0] m_hold();
        if (rst) return 3'b000;
        if (ex_jump_req || ex_busy || m_take()) return 3'b111;
        if (bus_hold) return 3'b001;
        return 3'b000;
    endfunction

    function automatic logic [31:0] m_jaddr();
        if (rst) return 32'h0;
        if (ex_jump_req) return ex_jump_addr;
        if (m_take()) return int_addr;
        return 32'h0;
    endfunction

    // Compare process
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model hold_flag", {29'b0, hold_flag}, {29'b0, m_hold()});
            chk("model jump_flag", {31'b0, jump_flag}, {31'b0, (!rst && (ex_jump_req || m_take()))});
            chk("model jump_addr", jump_addr, m_jaddr());
            chk("model int_ack", {31'b0, int_ack}, {31'b0, m_take()});
            chk("model int_epc", int_epc, m_epc);
            chk("model stall_timeout", {31'b0, stall_timeout}, {31'b0, m_to});
        end
    end

    // Model state update
    always @(posedge clk) begin : model_upd
        bit         tk;
        logic [2:0] h;
        tk = m_take();
        h  = m_hold();
        if (rst) begin
            m_pend = 0; m_stall = 0; m_took = 0; m_to = 0; m_cnt = 0; m_epc = 32'h0;
        end else begin
            if (tk) m_epc = ex_pc;
            m_pend  = tk ? 1'b0 : (m_pend || (int_req && !m_took));
            m_stall = m_stall ? ex_busy : (!m_took && ex_busy && !ex_jump_req);
            m_took  = tk;
            m_cnt   = (h != 3'b000) ? ((m_cnt < 511) ? m_cnt + 1 : 511) : 0;
            if (m_cnt >= int'(TO)) m_to = 1'b1;
        end
    end

    task automatic set_in(input bit jr, input logic [31:0] ja, input bit busy,
                          input bit bh, input bit ir);
        ex_jump_req  = jr;
        ex_jump_addr = ja;
        ex_busy      = busy;
        bus_hold     = bh;
        int_req      = ir;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ex_pc = 32'h44;
        int_addr = 32'h80;
        set_in(0, 32'h0, 0, 0, 0);
        nxt();
        chk_en = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst hold_flag", {29'b0, hold_flag}, 32'h0);
        chk("rst jump_flag", {31'b0, jump_flag}, 32'h0);
        chk("rst jump_addr", jump_addr, 32'h0);
        chk("rst int_ack", {31'b0, int_ack}, 32'h0);
        chk("rst int_epc", int_epc, 32'h0);
        chk("rst stall_timeout", {31'b0, stall_timeout}, 32'h0);
        nxt();
        rst = 1'b0;
        nxt();

        // single-cycle jump
        set_in(1, 32'h100, 0, 0, 0);
        @(negedge clk);
        chk("jmp hold", {29'b0, hold_flag}, 32'h7);
        chk("jmp flag", {31'b0, jump_flag}, 32'h1);
        chk("jmp addr", jump_addr, 32'h100);
        nxt();
        set_in(0, 32'h0, 0, 0, 0);
        @(negedge clk);
        chk("jmp after hold", {29'b0, hold_flag}, 32'h0);
        chk("jmp after flag", {31'b0, jump_flag}, 32'h0);
        chk("jmp after addr", jump_addr, 32'h0);
        nxt();

        // busy 5 cycles with jump in the third
        for (int i = 0; i < 5; i++) begin
            set_in(i == 2, 32'h200, 1, 0, 0);
            @(negedge clk);
            chk("busy hold", {29'b0, hold_flag}, 32'h7);
            chk("busy jump_flag", {31'b0, jump_flag}, (i == 2) ? 32'h1 : 32'h0);
            nxt();
        end
        set_in(0, 32'h0, 0, 0, 0);
        nxt();

        // interrupt arriving during busy waits for first RUN cycle
        for (int i = 0; i < 3; i++) begin
            set_in(0, 32'h0, 1, 0, i == 0);
            @(negedge clk);
            chk("int busy ack", {31'b0, int_ack}, 32'h0);
            nxt();
        end
        set_in(0, 32'h0, 0, 0, 0);
        @(negedge clk);
        chk("int stall exit ack", {31'b0, int_ack}, 32'h0);
        nxt();
        @(negedge clk);
        chk("int take ack", {31'b0, int_ack}, 32'h1);
        chk("int take addr", jump_addr, 32'h80);
        chk("int take hold", {29'b0, hold_flag}, 32'h7);
        nxt();
        @(negedge clk);
        chk("int epc", int_epc, 32'h44);
        chk("int_take ack low", {31'b0, int_ack}, 32'h0);
        nxt();

        // interrupt coincident with jump
        ex_pc = 32'h58;
        set_in(1, 32'h300, 0, 0, 1);
        @(negedge clk);
        chk("coinc jump addr", jump_addr, 32'h300);
        chk("coinc ack", {31'b0, int_ack}, 32'h0);
        nxt();
        set_in(0, 32'h0, 0, 0, 0);
        @(negedge clk);
        chk("coinc late ack", {31'b0, int_ack}, 32'h1);
        chk("coinc late addr", jump_addr, 32'h80);
        nxt();
        @(negedge clk);
        chk("coinc epc", int_epc, 32'h58);
        chk("coinc ack low", {31'b0, int_ack}, 32'h0);
        nxt();
        @(negedge clk);
        chk("coinc idle ack", {31'b0, int_ack}, 32'h0);
        nxt();

        // long bus hold trips the watchdog
        set_in(0, 32'h0, 0, 1, 0);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            chk("bushold hold", {29'b0, hold_flag}, 32'h1);
            chk("bushold timeout", {31'b0, stall_timeout}, (k >= 255) ? 32'h1 : 32'h0);
            nxt();
        end
        set_in(0, 32'h0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("timeout sticky", {31'b0, stall_timeout}, 32'h1);
            chk("bushold release", {29'b0, hold_flag}, 32'h0);
            nxt();
        end

        // reset with interrupt pending in STALL
        set_in(0, 32'h0, 1, 0, 0);
        nxt();
        set_in(0, 32'h0, 1, 0, 1);
        @(negedge clk);
        chk("stall int ack", {31'b0, int_ack}, 32'h0);
        nxt();
        rst = 1'b1;
        set_in(0, 32'h0, 1, 0, 0);
        @(negedge clk);
        chk("rst cyc hold", {29'b0, hold_flag}, 32'h0);
        chk("rst cyc jump", {31'b0, jump_flag}, 32'h0);
        chk("rst cyc addr", jump_addr, 32'h0);
        nxt();
        rst = 1'b0;
        set_in(0, 32'h0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post rst ack", {31'b0, int_ack}, 32'h0);
            chk("post rst timeout", {31'b0, stall_timeout}, 32'h0);
            chk("post rst epc", int_epc, 32'h0);
            nxt();
        end

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            rst      = ($urandom_range(0, 99) == 0);
            ex_pc    = $urandom;
            int_addr = $urandom;
            set_in($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
            nxt();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
